// File: rtl/division_if.sv
// Divider handshake bundle: the start pulse with its operands going in, and the
// result, remainder, ready pulse and exception flag coming back out.
interface division_if #(
  parameter int WIDTH = 32
);
  logic             ctrl_div;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic [WIDTH-1:0] out;
  logic [WIDTH-1:0] out_remainder;
  logic             data_resultRDY;
  logic             data_exception;

  // Requester side (execute stage): issues operations, consumes results.
  modport master (
    output ctrl_div, dividend, divisor,
    input  out, out_remainder, data_resultRDY, data_exception
  );

  // Divider side.
  modport slave (
    input  ctrl_div, dividend, divisor,
    output out, out_remainder, data_resultRDY, data_exception
  );
endinterface

// File: rtl/division.sv
// Multicycle signed integer divider. Operand magnitudes go through a
// restoring shift-subtract loop, one quotient bit per clock, and the signs are
// applied when the result is registered. Quotient truncates toward zero and the
// remainder takes the sign of the dividend. A new ctrl_div pulse always
// restarts the unit, silently dropping any operation still in flight.
module division #(
  parameter int WIDTH = 32
) (
  input  logic     clk,
  input  logic     reset,
  division_if.slave bus
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] ALL_ONE = {WIDTH{1'b1}};
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH);

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] quo_q, quo_d;          // dividend magnitude shifting into quotient
  logic [WIDTH-1:0] rem_q, rem_d;          // partial remainder, always < divisor
  logic [WIDTH-1:0] dvs_q, dvs_d;          // divisor magnitude
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sign_quo_q, sign_quo_d;
  logic             sign_rem_q, sign_rem_d;
  logic             exc_pend_q, exc_pend_d; // load saw an illegal operand pair
  logic [WIDTH-1:0] out_q, out_d;
  logic [WIDTH-1:0] out_rem_q, out_rem_d;
  logic             rdy_q, rdy_d;
  logic             exc_q, exc_d;

  // Magnitudes are taken as unsigned WIDTH-bit values, so the most negative
  // number maps onto 2^(WIDTH-1) without overflowing.
  logic [WIDTH-1:0] dvd_mag;
  logic [WIDTH-1:0] dvs_mag;
  logic             load_exc;
  logic [WIDTH:0]   shift_rem;   // one extra bit: shifted value can reach 2*divisor-1
  logic [WIDTH:0]   trial;

  assign dvd_mag  = bus.dividend[WIDTH-1] ? (~bus.dividend + 1'b1) : bus.dividend;
  assign dvs_mag  = bus.divisor[WIDTH-1]  ? (~bus.divisor  + 1'b1) : bus.divisor;
  assign load_exc = (bus.divisor == '0) ||
                    ((bus.dividend == MIN_VAL) && (bus.divisor == ALL_ONE));

  assign shift_rem = {rem_q, quo_q[WIDTH-1]};
  assign trial     = shift_rem - {1'b0, dvs_q};

  // Next-state logic: load beats everything, otherwise step the FSM.
  always_comb begin
    state_d    = state_q;
    quo_d      = quo_q;
    rem_d      = rem_q;
    dvs_d      = dvs_q;
    cnt_d      = cnt_q;
    sign_quo_d = sign_quo_q;
    sign_rem_d = sign_rem_q;
    exc_pend_d = exc_pend_q;
    out_d      = out_q;
    out_rem_d  = out_rem_q;
    rdy_d      = 1'b0;
    exc_d      = exc_q;

    if (bus.ctrl_div) begin
      state_d    = RUN;
      quo_d      = dvd_mag;
      rem_d      = '0;
      dvs_d      = dvs_mag;
      cnt_d      = '0;
      sign_quo_d = bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1];
      sign_rem_d = bus.dividend[WIDTH-1];
      exc_pend_d = load_exc;
      exc_d      = 1'b0;
    end else begin
      case (state_q)
        RUN: begin
          if (exc_pend_q) begin
            // Illegal operands: report on the very next edge, no iterations.
            out_d      = '0;
            out_rem_d  = '0;
            exc_d      = 1'b1;
            rdy_d      = 1'b1;
            exc_pend_d = 1'b0;
            state_d    = DONE;
          end else if (cnt_q != LAST_CNT) begin
            // Restoring step: keep the subtraction only if it did not go negative.
            if (!trial[WIDTH]) begin
              rem_d = trial[WIDTH-1:0];
              quo_d = {quo_q[WIDTH-2:0], 1'b1};
            end else begin
              rem_d = shift_rem[WIDTH-1:0];
              quo_d = {quo_q[WIDTH-2:0], 1'b0};
            end
            cnt_d = cnt_q + 1'b1;
          end else begin
            out_d     = sign_quo_q ? (~quo_q + 1'b1) : quo_q;
            out_rem_d = sign_rem_q ? (~rem_q + 1'b1) : rem_q;
            rdy_d     = 1'b1;
            state_d   = DONE;
          end
        end
        DONE: begin
          state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // State registers with synchronous reset taking priority over a start pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      quo_q      <= '0;
      rem_q      <= '0;
      dvs_q      <= '0;
      cnt_q      <= '0;
      sign_quo_q <= 1'b0;
      sign_rem_q <= 1'b0;
      exc_pend_q <= 1'b0;
      out_q      <= '0;
      out_rem_q  <= '0;
      rdy_q      <= 1'b0;
      exc_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      quo_q      <= quo_d;
      rem_q      <= rem_d;
      dvs_q      <= dvs_d;
      cnt_q      <= cnt_d;
      sign_quo_q <= sign_quo_d;
      sign_rem_q <= sign_rem_d;
      exc_pend_q <= exc_pend_d;
      out_q      <= out_d;
      out_rem_q  <= out_rem_d;
      rdy_q      <= rdy_d;
      exc_q      <= exc_d;
    end
  end

  assign bus.out            = out_q;
  assign bus.out_remainder  = out_rem_q;
  assign bus.data_resultRDY = rdy_q;
  assign bus.data_exception = exc_q;

endmodule

// File: tb/tb_division.sv
// Bench for the multicycle divider: directed operations with literal answers,
// a reference built on the language's truncating / and %, and a per-cycle
// comparison of every output against that reference.
`timescale 1ns/1ps
module tb_division;
  localparam int W = 32;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  division_if #(.WIDTH(W)) dif();

  division #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (dif.slave)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- reference arithmetic ----------------
  function automatic logic ref_exc(input logic [31:0] a, input logic [31:0] b);
    return (b == 32'd0) || (a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
  endfunction

  function automatic logic [31:0] ref_quo(input logic [31:0] a, input logic [31:0] b);
    int sa;
    int sb;
    if (ref_exc(a, b)) return 32'd0;
    sa = a;
    sb = b;
    return sa / sb;
  endfunction

  function automatic logic [31:0] ref_rem(input logic [31:0] a, input logic [31:0] b);
    int sa;
    int sb;
    if (ref_exc(a, b)) return 32'd0;
    sa = a;
    sb = b;
    return sa % sb;
  endfunction

  logic [31:0] ld_q, ld_r;
  logic        ld_e;
  assign ld_q = ref_quo(dif.dividend, dif.divisor);
  assign ld_r = ref_rem(dif.dividend, dif.divisor);
  assign ld_e = ref_exc(dif.dividend, dif.divisor);

  // ---------------- cycle model: result lands a fixed time after the last load
  logic        model_valid = 1'b0;
  logic        exp_rdy = 1'b0;
  logic [31:0] exp_out = '0, exp_rem = '0;
  logic        exp_exc = 1'b0;
  int          countdown = 0;
  logic [31:0] pend_q = '0, pend_r = '0;
  logic        pend_e = 1'b0;

  always @(posedge clk) begin
    if (reset) begin
      model_valid <= 1'b1;
      exp_rdy     <= 1'b0;
      exp_out     <= '0;
      exp_rem     <= '0;
      exp_exc     <= 1'b0;
      countdown   <= 0;
    end else if (dif.ctrl_div) begin
      pend_q    <= ld_q;
      pend_r    <= ld_r;
      pend_e    <= ld_e;
      countdown <= ld_e ? 1 : W + 1;
      exp_rdy   <= 1'b0;
      exp_exc   <= 1'b0;
    end else if (countdown > 0) begin
      countdown <= countdown - 1;
      if (countdown == 1) begin
        exp_rdy <= 1'b1;
        exp_out <= pend_q;
        exp_rem <= pend_r;
        exp_exc <= pend_e;
      end else begin
        exp_rdy <= 1'b0;
      end
    end else begin
      exp_rdy <= 1'b0;
    end
  end

  // Every cycle: ready, outputs (held between results) and exception flag.
  always @(negedge clk) begin
    if (model_valid) begin
      check("cyc_rdy", {31'd0, dif.data_resultRDY}, {31'd0, exp_rdy});
      check("cyc_out", dif.out, exp_out);
      check("cyc_rem", dif.out_remainder, exp_rem);
      check("cyc_exc", {31'd0, dif.data_exception}, {31'd0, exp_exc});
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic pulse(input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    dif.dividend = a;
    dif.divisor  = b;
    dif.ctrl_div = 1'b1;
    @(negedge clk);
    dif.ctrl_div = 1'b0;
  endtask

  // Called at the negedge just after the load edge; lat counts edges since it.
  task automatic wait_check(input logic [31:0] eq, input logic [31:0] er,
                            input logic ee, input string tag);
    int lat;
    lat = 0;
    while (dif.data_resultRDY !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check({tag, "_latency"}, lat, ee ? 32'd1 : 32'd33);
    check({tag, "_out"}, dif.out, eq);
    check({tag, "_rem"}, dif.out_remainder, er);
    check({tag, "_exc"}, {31'd0, dif.data_exception}, {31'd0, ee});
    $display("op %s: q=%0d r=%0d exc=%0b latency=%0d", tag,
             $signed(dif.out), $signed(dif.out_remainder), dif.data_exception, lat);
    @(negedge clk);
    check({tag, "_rdy_drop"}, {31'd0, dif.data_resultRDY}, 32'd0);
    check({tag, "_hold"}, dif.out, eq);
  endtask

  task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] eq, input logic [31:0] er,
                        input logic ee, input string tag);
    pulse(a, b);
    wait_check(eq, er, ee, tag);
  endtask

  task automatic watch_no_rdy(input int n, input string tag);
    int seen;
    seen = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (dif.data_resultRDY === 1'b1) seen++;
    end
    check({tag, "_no_rdy"}, seen, 32'd0);
    $display("op %s: watched %0d cycles, rdy pulses=%0d", tag, n, seen);
  endtask

  logic [31:0] extremes [12] = '{32'd0, 32'd1, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFE,
                                 32'd7, 32'hFFFF_FFF9, 32'h7FFF_FFFF, 32'h8000_0000,
                                 32'h8000_0001, 32'd100, 32'hFFFF_FF9C};

  initial begin
    logic [31:0] a, b;
    dif.ctrl_div = 1'b0;
    dif.dividend = '0;
    dif.divisor  = '0;
    repeat (3) @(negedge clk);
    check("reset_out", dif.out, 32'd0);
    check("reset_rem", dif.out_remainder, 32'd0);
    check("reset_rdy", {31'd0, dif.data_resultRDY}, 32'd0);
    check("reset_exc", {31'd0, dif.data_exception}, 32'd0);
    reset = 1'b0;

    // Signed combinations with literal answers.
    run_op(32'd100,        32'd7,          32'd14,         32'd2,          1'b0, "100/7");
    run_op(-32'sd100,      32'd7,          32'hFFFF_FFF2,  32'hFFFF_FFFE,  1'b0, "-100/7");
    run_op(32'd100,        -32'sd7,        32'hFFFF_FFF2,  32'd2,          1'b0, "100/-7");
    run_op(-32'sd100,      -32'sd7,        32'd14,         32'hFFFF_FFFE,  1'b0, "-100/-7");
    run_op(32'd7,          32'd0,          32'd0,          32'd0,          1'b1, "7/0");
    run_op(32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          32'd0,          1'b1, "min/-1");
    run_op(32'h8000_0000,  32'd1,          32'h8000_0000,  32'd0,          1'b0, "min/1");
    run_op(32'd0,          32'd5,          32'd0,          32'd0,          1'b0, "0/5");
    run_op(-32'sd3,        32'd10,         32'd0,          32'hFFFF_FFFD,  1'b0, "-3/10");
    run_op(32'h8000_0000,  32'h8000_0000,  32'd1,          32'd0,          1'b0, "min/min");

    // Restart while busy: only the second operation reports.
    pulse(32'd1000, 32'd3);
    repeat (8) @(negedge clk);
    run_op(32'd50, 32'd5, 32'd10, 32'd0, 1'b0, "restart");

    // ctrl_div held high while operands change: last high edge wins.
    @(negedge clk);
    dif.dividend = 32'd20;
    dif.divisor  = 32'd3;
    dif.ctrl_div = 1'b1;
    @(negedge clk);
    @(negedge clk);
    dif.dividend = 32'd21;
    dif.divisor  = 32'd4;
    @(negedge clk);
    dif.ctrl_div = 1'b0;
    wait_check(32'd5, 32'd1, 1'b0, "held");

    // Reset mid-operation clears everything and no result ever appears.
    pulse(32'd1000, 32'd3);
    repeat (18) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("midreset_out", dif.out, 32'd0);
    check("midreset_rem", dif.out_remainder, 32'd0);
    check("midreset_rdy", {31'd0, dif.data_resultRDY}, 32'd0);
    watch_no_rdy(40, "midreset");

    // Reset and start on the same edge: reset wins.
    run_op(32'd9, 32'd2, 32'd4, 32'd1, 1'b0, "pre_sameedge");
    @(negedge clk);
    reset = 1'b1;
    dif.dividend = 32'd9;
    dif.divisor  = 32'd3;
    dif.ctrl_div = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    dif.ctrl_div = 1'b0;
    check("sameedge_out", dif.out, 32'd0);
    watch_no_rdy(40, "sameedge");

    // Mixed operands: extremes and random values against the reference.
    for (int i = 0; i < 24; i++) begin
      a = ($urandom_range(0, 1) == 0) ? extremes[$urandom_range(0, 11)] : $urandom;
      b = ($urandom_range(0, 1) == 0) ? extremes[$urandom_range(0, 11)] : $urandom;
      if (i % 6 == 5) b = $urandom_range(1, 9);
      run_op(a, b, ref_quo(a, b), ref_rem(a, b), ref_exc(a, b), $sformatf("mix%0d", i));
    end

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
